follow_distance_monitor: RTL and testbench
==========================================

# follow_distance_monitor

Front-end for the forward range sensor that produces the `too_close` and `approaching_object` inputs consumed by the cruise-control state machine. It samples a distance reading on each strobe, applies hysteresis to the short-distance flag, and derives a closing rate from consecutive samples. It confirms a fast approach over several samples and fails safe if the sensor stops reporting. It sits between the sensor interface (or board switches/bench stimulus) and the cruise-control core, in the same 50 MHz `clk` domain.

## Interface
Parameters:
- `TOO_CLOSE_ON`, 10 — distance in feet below which `too_close` sets.
- `TOO_CLOSE_OFF`, 12 — distance in feet at or above which `too_close` clears. Must be ≥ `TOO_CLOSE_ON`.
- `CLOSE_RATE`, 3 — minimum closing rate, in feet per sample, that qualifies a sample as approaching.
- `CONFIRM`, 2 — number of consecutive qualifying samples required to assert `approaching_object`.
- `TIMEOUT`, 25000000 — number of clocks without `sample_valid` before a fault is declared.

Ports:
- `clk` in 1 — system clock.
- `rst` in 1 — synchronous, active-high reset.
- `sample_valid` in 1 — single-cycle strobe; `distance` is valid on this cycle.
- `distance` in 7 — range to target in feet. 127 means no target.
- `current_speed` in 7 — vehicle speed in mph (0–64).
- `too_close` out 1 — registered flag: target is inside the hysteresis band.
- `approaching_object` out 1 — registered flag: confirmed fast closing.
- `closing_rate` out 7 — registered closing rate of the last sample, in feet per sample.
- `sensor_fault` out 1 — registered flag: sample watchdog has expired.

## Operation
- Reset values: all outputs 0, `prev_dist` 0, `approach_cnt` 0, watchdog 0, state `NO_REF`.
- States and transitions:
  - `NO_REF` (no previous sample): on `sample_valid`, store `prev_dist`, force `closing_rate` to 0, clear `approach_cnt`, evaluate `too_close`, then go to `TRACK`.
  - `TRACK`: on `sample_valid`, compute the closing rate as `prev_dist - distance` if `prev_dist > distance`, else 0. Compute 8 bits wide; the result always fits in 7 bits. Then set `prev_dist` ← `distance`.
  - `FAULT`: on `sample_valid`, clear `sensor_fault` and handle the sample exactly as in `NO_REF` (go to `TRACK`).
- Qualifying sample: closing rate ≥ `CLOSE_RATE` and `current_speed` ≠ 0.
  - A qualifying sample increments `approach_cnt`, saturating at `CONFIRM`.
  - Any other sample clears `approach_cnt` to 0.
  - `approaching_object` = (`approach_cnt` == `CONFIRM`). It asserts on the `CONFIRM`-th consecutive qualifying sample and drops on the first non-qualifying one.
- `too_close` hysteresis, evaluated on every accepted sample:
  - `distance` < `TOO_CLOSE_ON` → set.
  - `distance` ≥ `TOO_CLOSE_OFF` → clear.
  - Otherwise hold the previous value.
- No-target sample (`distance` == 127):
  - clears `too_close`, `closing_rate` and `approach_cnt`;
  - stores 127 into `prev_dist`;
  - the next real sample yields rate 0 (127 > any real value, but it is forced to 0 because the previous sample was no-target).
- Watchdog:
  - Counts clocks since the last `sample_valid` and saturates.
  - On reaching `TIMEOUT`: go to `FAULT`, set `sensor_fault`=1 and `too_close`=1 (fail-safe deceleration), clear `approaching_object`, `closing_rate` and `approach_cnt`.
- Outputs hold their values between samples.

## Timing
- Latency: all outputs update on the rising edge at which `sample_valid` is sampled high and are visible the following cycle. The path from `sample_valid` to any output is exactly 1 clock.
- Back-to-back `sample_valid` (every cycle) is supported; each strobe is one independent sample.
- `sample_valid` on the same cycle the watchdog reaches `TIMEOUT`: the sample wins. The watchdog resets to 0 and no fault is raised.
- `rst` asserted mid-operation takes priority over everything. All state returns to reset values on that edge; a `sample_valid` in the same cycle is discarded.
- `current_speed` is sampled only on `sample_valid` cycles.

## Test plan
- Reset, then samples 40, 36, 32, 28 with `current_speed`=30 → `closing_rate` = 0, 4, 4, 4; `approaching_object` rises 1 cycle after the sample 32 strobe and stays high after the sample 28 strobe.
- Samples 40, 36, 35 with `current_speed`=30 → `approaching_object` never asserts; `approach_cnt` clears after the sample 35 strobe (rate 1).
- Samples 15, 9, 11, 12, 11 → `too_close` = 0, 1, 1, 0, 0 (hysteresis band 10–11 holds the previous value).
- No `sample_valid` for `TIMEOUT` clocks (use `TIMEOUT`=16) → `sensor_fault`=1 and `too_close`=1 exactly at count 16. Next sample 50 → `sensor_fault`=0, `too_close`=0, `closing_rate`=0.
- Sample 30, then `rst` and `sample_valid` (distance 20) asserted in the same cycle → all outputs 0, state `NO_REF`. Next sample 25 gives rate 0.
- Samples 40, 36, 32 with `current_speed`=0 → `approaching_object` stays 0 while `closing_rate` reads 4.

Source files
------------

// File: rtl/follow_distance_monitor.sv
// Range-sensor front end: too_close hysteresis, closing-rate
// estimate with approach confirmation, and a sample watchdog.
module follow_distance_monitor #(
  parameter int TOO_CLOSE_ON  = 10,
  parameter int TOO_CLOSE_OFF = 12,
  parameter int CLOSE_RATE    = 3,
  parameter int CONFIRM       = 2,
  parameter int TIMEOUT       = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [6:0] distance,
  input  logic [6:0] current_speed,
  output logic       too_close,
  output logic       approaching_object,
  output logic [6:0] closing_rate,
  output logic       sensor_fault
);

  localparam int CW = $clog2(CONFIRM + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [6:0]    NO_TGT = 7'd127;
  localparam logic [6:0]    ON_C   = 7'(TOO_CLOSE_ON);
  localparam logic [6:0]    OFF_C  = 7'(TOO_CLOSE_OFF);
  localparam logic [6:0]    RATE_C = 7'(CLOSE_RATE);
  localparam logic [CW-1:0] CONF_C = CW'(CONFIRM);
  localparam logic [WW-1:0] TOUT_C = WW'(TIMEOUT);
  localparam logic [WW-1:0] WD_LST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    NO_REF = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [6:0]    prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          tc_q, tc_d;
  logic          ao_q, ao_d;
  logic [6:0]    rate_q, rate_d;
  logic          flt_q, flt_d;

  logic       timeout_hit;
  logic       has_ref;
  logic       no_tgt;
  logic       gt;
  logic       qual;
  logic [7:0] diff;
  logic [6:0] raw_rate;

  assign timeout_hit = !sample_valid && (wdog_q == WD_LST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NO_REF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      sample_valid: state_d = TRACK;
      timeout_hit:  state_d = FAULT;
      default:      state_d = state_q;
    endcase
  end

  // A reference only exists after a real sample while tracking
  assign has_ref  = (state_q == TRACK) && (prev_q != NO_TGT);
  assign no_tgt   = (distance == NO_TGT);
  assign diff     = {1'b0, prev_q} - {1'b0, distance};
  assign gt       = !diff[7] && (diff[6:0] != 7'd0);
  assign raw_rate = (has_ref && gt) ? diff[6:0] : 7'd0;
  assign qual     = has_ref && !no_tgt &&
                    (raw_rate >= RATE_C) &&
                    (current_speed != 7'd0);

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    tc_d   = tc_q;
    ao_d   = ao_q;
    rate_d = rate_q;
    flt_d  = flt_q;
    wdog_d = (wdog_q == TOUT_C) ? wdog_q
                                : wdog_q + 1'b1;
    if (sample_valid) begin
      wdog_d = '0;
      prev_d = distance;
      flt_d  = 1'b0;
      rate_d = no_tgt ? 7'd0 : raw_rate;
      if (!qual) begin
        cnt_d = '0;
      end else if (cnt_q != CONF_C) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (no_tgt) begin
        tc_d = 1'b0;
      end else if (distance < ON_C) begin
        tc_d = 1'b1;
      end else if (distance >= OFF_C) begin
        tc_d = 1'b0;
      end
      ao_d = (cnt_d == CONF_C);
    end else if (timeout_hit) begin
      // Lost sensor: force a decel request
      flt_d  = 1'b1;
      tc_d   = 1'b1;
      ao_d   = 1'b0;
      rate_d = 7'd0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      cnt_q  <= '0;
      wdog_q <= '0;
      tc_q   <= 1'b0;
      ao_q   <= 1'b0;
      rate_q <= '0;
      flt_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      wdog_q <= wdog_d;
      tc_q   <= tc_d;
      ao_q   <= ao_d;
      rate_q <= rate_d;
      flt_q  <= flt_d;
    end
  end

  assign too_close          = tc_q;
  assign approaching_object = ao_q;
  assign closing_rate       = rate_q;
  assign sensor_fault       = flt_q;

endmodule

// File: tb/tb_follow_distance_monitor.sv
// Directed-vector bench for follow_distance_monitor with a
// queue scoreboard checked by an independent monitor.
module tb_follow_distance_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [6:0] distance = '0;
  logic [6:0] current_speed = '0;
  logic       too_close;
  logic       approaching_object;
  logic [6:0] closing_rate;
  logic       sensor_fault;

  logic chk = 1'b0;
  logic chk_d = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string      nm;
    logic       tc;
    logic       ao;
    logic [6:0] r;
    logic       f;
  } exp_t;

  exp_t sbq[$];

  follow_distance_monitor #(
    .TOO_CLOSE_ON (10),
    .TOO_CLOSE_OFF(12),
    .CLOSE_RATE   (3),
    .CONFIRM      (2),
    .TIMEOUT      (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .sample_valid      (sample_valid),
    .distance          (distance),
    .current_speed     (current_speed),
    .too_close         (too_close),
    .approaching_object(approaching_object),
    .closing_rate      (closing_rate),
    .sensor_fault      (sensor_fault)
  );

  always #10 clk = ~clk;

  always @(posedge clk) chk_d <= chk;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_d) begin
        n_vec++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL underflow: check with no expected entry");
        end else begin
          e = sbq.pop_front();
          if (too_close !== e.tc ||
              approaching_object !== e.ao ||
              closing_rate !== e.r ||
              sensor_fault !== e.f) begin
            n_bad++;
            $display("FAIL %s: got tc=%b ao=%b rate=%0d flt=%b want tc=%b ao=%b rate=%0d flt=%b",
                     e.nm, too_close, approaching_object,
                     closing_rate, sensor_fault,
                     e.tc, e.ao, e.r, e.f);
          end
        end
      end
    end
  end

  function automatic exp_t mk(string nm, bit tc, bit ao,
                              int r, bit f);
    exp_t e;
    e.nm = nm;
    e.tc = tc;
    e.ao = ao;
    e.r  = 7'(r);
    e.f  = f;
    return e;
  endfunction

  task automatic step(input bit sv, input int d, input int s,
                      input bit r, input bit c, input exp_t e);
    @(negedge clk);
    sample_valid  = sv;
    distance      = 7'(d);
    current_speed = 7'(s);
    rst           = r;
    chk           = c;
    if (c) sbq.push_back(e);
  endtask

  task automatic smp(string nm, int d, int s,
                     bit tc, bit ao, int r, bit f);
    step(1'b1, d, s, 1'b0, 1'b1, mk(nm, tc, ao, r, f));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 0, 0, 1'b0, 1'b0, mk("", 0, 0, 0, 0));
  endtask

  task automatic idle_chk(string nm, bit tc, bit ao,
                          int r, bit f);
    step(1'b0, 0, 0, 1'b0, 1'b1, mk(nm, tc, ao, r, f));
  endtask

  task automatic do_reset(string nm);
    step(1'b0, 0, 0, 1'b1, 1'b1, mk(nm, 0, 0, 0, 0));
  endtask

  initial begin
    do_reset("reset_state");

    smp("t1_40", 40, 30, 0, 0, 0, 0);
    smp("t1_36", 36, 30, 0, 0, 4, 0);
    smp("t1_32", 32, 30, 0, 1, 4, 0);
    smp("t1_28", 28, 30, 0, 1, 4, 0);
    idle(1);
    idle_chk("t1_hold", 0, 1, 4, 0);

    do_reset("t2_reset");
    smp("t2_40", 40, 30, 0, 0, 0, 0);
    smp("t2_36", 36, 30, 0, 0, 4, 0);
    smp("t2_35", 35, 30, 0, 0, 1, 0);
    smp("t2_31", 31, 30, 0, 0, 4, 0);
    smp("t2_27", 27, 30, 0, 1, 4, 0);
    smp("t2_24_rate3", 24, 30, 0, 1, 3, 0);
    smp("t2_22_rate2", 22, 30, 0, 0, 2, 0);

    do_reset("t3_reset");
    smp("t3_15", 15, 0, 0, 0, 0, 0);
    smp("t3_9", 9, 0, 1, 0, 6, 0);
    smp("t3_11", 11, 0, 1, 0, 0, 0);
    smp("t3_12", 12, 0, 0, 0, 0, 0);
    smp("t3_11b", 11, 0, 0, 0, 1, 0);

    do_reset("t4_reset");
    smp("t4_40", 40, 30, 0, 0, 0, 0);
    smp("t4_36", 36, 30, 0, 0, 4, 0);
    smp("t4_32", 32, 30, 0, 1, 4, 0);
    idle(14);
    idle_chk("wd_count15", 0, 1, 4, 0);
    idle_chk("wd_count16", 1, 0, 0, 1);
    idle(3);
    idle_chk("wd_saturated", 1, 0, 0, 1);
    smp("fault_50", 50, 30, 0, 0, 0, 0);
    smp("fault_46", 46, 30, 0, 0, 4, 0);
    idle(15);
    smp("wd_tie_42", 42, 30, 0, 1, 4, 0);
    idle_chk("wd_tie_after", 0, 1, 4, 0);

    do_reset("t5_reset");
    smp("t5_30", 30, 30, 0, 0, 0, 0);
    step(1'b1, 20, 30, 1'b1, 1'b1,
         mk("t5_rst_with_sample", 0, 0, 0, 0));
    smp("t5_25", 25, 30, 0, 0, 0, 0);

    do_reset("t6_reset");
    smp("t6_40", 40, 0, 0, 0, 0, 0);
    smp("t6_36", 36, 0, 0, 0, 4, 0);
    smp("t6_32", 32, 0, 0, 0, 4, 0);

    do_reset("t7_reset");
    smp("t7_20", 20, 30, 0, 0, 0, 0);
    smp("t7_5", 5, 30, 1, 0, 15, 0);
    smp("t7_notgt", 127, 30, 0, 0, 0, 0);
    smp("t7_3_after_nt", 3, 30, 1, 0, 0, 0);
    smp("t7_0", 0, 30, 1, 0, 3, 0);

    idle(2);
    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0",
               sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
